// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: table command codes, master transaction types
// and the init-sequencer state encoding.
package sccb_pkg;

    localparam logic [15:0] CMD_DELAY = 16'hFFFF;
    localparam logic [15:0] CMD_END   = 16'hFFFE;

    localparam logic [1:0] SCCB_WR_WRITE = 2'b00;
    localparam logic [1:0] SCCB_WR_READ1 = 2'b01;
    localparam logic [1:0] SCCB_WR_READ2 = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    // Full 32-bit product; exact for units <= 255 and unit_cycles < 2**24.
    function automatic logic [31:0] dly_cycles(input logic [7:0]  units,
                                               input logic [31:0] unit_cycles);
        return {24'd0, units} * unit_cycles;
    endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// Synchronous init-table ROM, one-cycle read latency. Contents come from the
// per-sensor table via INIT (entry 0 in the least-significant 24 bits).
module sccb_init_rom #(
    parameter int unsigned                   ADDR_W = 8,
    parameter logic [24*(2**ADDR_W)-1:0]     INIT   = '0
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [23:0]       o_data
);

    logic [23:0] w_mem [2**ADDR_W];

    for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_mem
        assign w_mem[g] = INIT[24*g +: 24];
    end

    always_ff @(posedge i_clk) begin
        o_data <= w_mem[i_addr];
    end

endmodule

// File: rtl/sccb_init_seq.sv
// Camera register-init sequencer: walks the table ROM and issues one SCCB
// write per entry, with embedded delay and end-of-table commands.
module sccb_init_seq
    import sccb_pkg::*;
#(
    parameter logic [7:0]  DEV_ID   = 8'h78,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DLY_UNIT = 100000,
    parameter int unsigned ACK_TMO  = 15
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_go,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [23:0]       i_rom_data,
    output logic              o_sccb_start,
    output logic [1:0]        o_sccb_wr,
    output logic [31:0]       o_sccb_data,
    input  logic              i_sccb_busy,
    output logic              o_seq_busy,
    output logic              o_seq_done,
    output logic              o_seq_err,
    output logic [ADDR_W-1:0] o_seq_index
);

    // WAIT_ACK is entered one cycle after the start pulse, so the counter
    // covers the remaining ACK_TMO-1 evaluations down to terminal count.
    localparam logic [15:0] TMO_LOAD = 16'(ACK_TMO - 2);
    localparam logic [31:0] DLY_U32  = 32'(DLY_UNIT);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_index;
    logic              r_start;
    logic [31:0]       r_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_dly;
    logic [15:0]       r_tmo;

    logic [15:0]       w_sub;
    logic [7:0]        w_dat;
    logic [31:0]       w_dly_load;

    assign w_sub      = i_rom_data[23:8];
    assign w_dat      = i_rom_data[7:0];
    assign w_dly_load = dly_cycles(w_dat, DLY_U32) - 32'd1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_start <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_dly   <= '0;
            r_tmo   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_go) begin
                        r_state <= ST_FETCH;
                        r_index <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_sub == CMD_END) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_sub == CMD_DELAY) begin
                        if (w_dat == 8'd0) begin
                            r_state <= ST_NEXT;
                        end else begin
                            r_dly   <= w_dly_load;
                            r_state <= ST_DELAY;
                        end
                    end else begin
                        // Start is raised here so it is high for the ISSUE cycle.
                        r_data  <= {DEV_ID, i_rom_data};
                        r_start <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_tmo   <= TMO_LOAD;
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (i_sccb_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_tmo == 16'd0) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo - 16'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_sccb_busy) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_DELAY: begin
                    if (r_dly == 32'd0) begin
                        r_state <= ST_NEXT;
                    end else begin
                        r_dly <= r_dly - 32'd1;
                    end
                end
                ST_NEXT: begin
                    if (r_index == {ADDR_W{1'b1}}) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_index <= r_index + 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr   = r_index;
    assign o_seq_index  = r_index;
    assign o_sccb_start = r_start;
    assign o_sccb_wr    = SCCB_WR_WRITE;
    assign o_sccb_data  = r_data;
    assign o_seq_busy   = r_busy;
    assign o_seq_done   = r_done;
    assign o_seq_err    = r_err;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench for sccb_init_seq with a table-ROM model and a behavioural
// SCCB master (Busy rises the cycle after start and is held HOLD cycles).
module tb_sccb_init_seq;

    localparam int AW   = 2;
    localparam int DLY  = 10;
    localparam int TMO  = 15;
    localparam int HOLD = 40;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          go   = 1'b0;
    logic          busy = 1'b0;
    logic [23:0]   rom_data;
    logic [23:0]   tbl [4];
    logic [AW-1:0] rom_addr;
    logic          start;
    logic [1:0]    wr;
    logic [31:0]   sdata;
    logic          seq_busy, seq_done, seq_err;
    logic [AW-1:0] seq_index;

    logic [1:0]    rchk_addr = 2'd0;
    logic [23:0]   rchk_data;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int          start_cyc [$];
    logic [31:0] start_dat [$];
    int          fall_q    [$];
    int          busy_left = 0;
    bit          pend      = 0;
    bit          master_en = 1;
    bit          prev_start = 0;
    int          dbl       = 0;

    sccb_init_seq #(
        .DEV_ID(8'h78), .ADDR_W(AW), .DLY_UNIT(DLY), .ACK_TMO(TMO)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_go(go),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_sccb_start(start), .o_sccb_wr(wr), .o_sccb_data(sdata),
        .i_sccb_busy(busy),
        .o_seq_busy(seq_busy), .o_seq_done(seq_done), .o_seq_err(seq_err),
        .o_seq_index(seq_index)
    );

    sccb_init_rom #(
        .ADDR_W(2),
        .INIT({24'hFFFE00, 24'h310303, 24'hFFFF03, 24'h300882})
    ) u_rom (
        .i_clk(clk), .i_addr(rchk_addr), .o_data(rchk_data)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= tbl[rom_addr];
    end

    // Master model and start-pulse log, evaluated mid-cycle.
    initial forever begin
        @(negedge clk);
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                busy = 1'b0;
                fall_q.push_back(cyc);
            end
        end
        if (pend) begin
            busy      = 1'b1;
            busy_left = HOLD;
            pend      = 0;
        end
        if (start === 1'b1) begin
            if (prev_start) dbl++;
            start_cyc.push_back(cyc);
            start_dat.push_back(sdata);
            if (master_en) pend = 1;
        end
        prev_start = (start === 1'b1);
    end

    task automatic clear_log();
        start_cyc.delete();
        start_dat.delete();
        fall_q.delete();
        dbl = 0;
    endtask

    task automatic pulse_go();
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    task automatic wait_seq_end(input string name, input int budget);
        int n = 0;
        while (seq_busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: seq_busy=%b after %0d cycles, required 0", name, seq_busy, budget);
        end
    endtask

    task automatic wait_starts(input int want, input int budget);
        int n = 0;
        while (start_cyc.size() < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (start_cyc.size() < want) begin
            n_fail++;
            $display("FAIL wait_starts: got %0d starts, required %0d", start_cyc.size(), want);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({start, wr, sdata, seq_busy, seq_done, seq_err, seq_index, rom_addr} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {start, wr, sdata, seq_busy, seq_done, seq_err, seq_index, rom_addr});
        end
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++;
        if (start_cyc.size() != 0 || seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: starts=%0d seq_busy=%b, required 0 and 0", start_cyc.size(), seq_busy);
        end
    endtask

    task automatic test_rom();
        @(negedge clk) rchk_addr = 2'd1;
        @(negedge clk);
        n_chk++;
        if (rchk_data !== 24'hFFFF03) begin
            n_fail++;
            $display("FAIL rom_read1: got %h, required FFFF03", rchk_data);
        end
        rchk_addr = 2'd3;
        @(negedge clk);
        n_chk++;
        if (rchk_data !== 24'hFFFE00) begin
            n_fail++;
            $display("FAIL rom_read3: got %h, required FFFE00", rchk_data);
        end
    endtask

    task automatic test_two_writes();
        tbl = '{24'h300882, 24'h310303, 24'hFFFE00, 24'h000000};
        clear_log();
        master_en = 1;
        pulse_go();
        n_chk++;
        if (seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL two_busy_after_go: got %b, required 1", seq_busy);
        end
        wait_seq_end("two", 500);
        n_chk++;
        if (start_cyc.size() != 2 || dbl != 0) begin
            n_fail++;
            $display("FAIL two_start_count: got %0d (double=%0d), required 2 (0)", start_cyc.size(), dbl);
        end else begin
            n_chk++;
            if (start_dat[0] !== 32'h78300882) begin
                n_fail++;
                $display("FAIL two_data0: got %h, required 78300882", start_dat[0]);
            end
            n_chk++;
            if (start_dat[1] !== 32'h78310303) begin
                n_fail++;
                $display("FAIL two_data1: got %h, required 78310303", start_dat[1]);
            end
            // HOLD busy cycles + 1 detect cycle + NEXT/FETCH/DECODE/ISSUE.
            n_chk++;
            if (start_cyc[1] - start_cyc[0] != HOLD + 5) begin
                n_fail++;
                $display("FAIL two_gap: got %0d, required %0d", start_cyc[1] - start_cyc[0], HOLD + 5);
            end
        end
        n_chk++;
        if ({seq_done, seq_err, seq_index, wr} !== {1'b1, 1'b0, 2'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL two_end_state: done/err/index/wr got %b/%b/%0d/%b, required 1/0/2/00",
                     seq_done, seq_err, seq_index, wr);
        end
    endtask

    task automatic test_delay();
        tbl = '{24'h300882, 24'hFFFF03, 24'h310303, 24'hFFFE00};
        clear_log();
        pulse_go();
        wait_seq_end("dly", 800);
        n_chk++;
        if (start_cyc.size() != 2 || fall_q.size() < 1) begin
            n_fail++;
            $display("FAIL dly_start_count: got %0d starts, %0d falls, required 2, >=1",
                     start_cyc.size(), fall_q.size());
        end else begin
            // 3*DLY wait + 7 overhead cycles (NEXT, FETCH, DECODE, NEXT, FETCH, DECODE, ISSUE).
            n_chk++;
            if (start_cyc[1] - fall_q[0] != 3 * DLY + 7) begin
                n_fail++;
                $display("FAIL dly_gap: got %0d, required %0d", start_cyc[1] - fall_q[0], 3 * DLY + 7);
            end
        end
        n_chk++;
        if (seq_done !== 1'b1 || seq_index !== 2'd3) begin
            n_fail++;
            $display("FAIL dly_end_state: done=%b index=%0d, required 1 and 3", seq_done, seq_index);
        end
    endtask

    task automatic test_timeout();
        int err_cyc = -1;
        int n = 0;
        tbl = '{24'h300882, 24'hFFFE00, 24'h000000, 24'h000000};
        clear_log();
        master_en = 0;
        pulse_go();
        while (seq_err !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (seq_err === 1'b1) err_cyc = cyc;
        n_chk++;
        if (start_cyc.size() != 1 || err_cyc < 0) begin
            n_fail++;
            $display("FAIL tmo_err_seen: starts=%0d err_cyc=%0d, required 1 start and err set",
                     start_cyc.size(), err_cyc);
        end else begin
            n_chk++;
            if (err_cyc - start_cyc[0] != TMO) begin
                n_fail++;
                $display("FAIL tmo_latency: got %0d, required %0d", err_cyc - start_cyc[0], TMO);
            end
        end
        n_chk++;
        if ({seq_busy, seq_done, seq_index} !== {1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL tmo_state: busy/done/index got %b/%b/%0d, required 0/0/0",
                     seq_busy, seq_done, seq_index);
        end
        master_en = 1;
        clear_log();
        pulse_go();
        n_chk++;
        if (seq_err !== 1'b0 || seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_restart: err=%b busy=%b, required 0 and 1", seq_err, seq_busy);
        end
        wait_seq_end("tmo_restart", 500);
        n_chk++;
        if (seq_done !== 1'b1 || seq_err !== 1'b0 || start_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL tmo_rerun: done=%b err=%b starts=%0d, required 1/0/1",
                     seq_done, seq_err, start_cyc.size());
        end
    endtask

    task automatic test_wrap();
        tbl = '{24'h300101, 24'h300202, 24'h300303, 24'h300404};
        clear_log();
        pulse_go();
        wait_seq_end("wrap", 800);
        repeat (60) @(negedge clk);
        n_chk++;
        if (start_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_start_count: got %0d, required 4", start_cyc.size());
        end else begin
            n_chk++;
            if (start_dat[3] !== 32'h78300404 || start_dat[0] !== 32'h78300101) begin
                n_fail++;
                $display("FAIL wrap_data: first %h last %h, required 78300101 78300404",
                         start_dat[0], start_dat[3]);
            end
        end
        n_chk++;
        if (seq_done !== 1'b1 || seq_index !== 2'd3 || seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end_state: done=%b index=%0d busy=%b, required 1/3/0",
                     seq_done, seq_index, seq_busy);
        end
    endtask

    task automatic test_reset_mid();
        tbl = '{24'h300101, 24'h300202, 24'h300303, 24'h300404};
        clear_log();
        pulse_go();
        wait_starts(2, 300);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({start, wr, sdata, seq_busy, seq_done, seq_err, seq_index, rom_addr} !== 42'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %h, required 0",
                     {start, wr, sdata, seq_busy, seq_done, seq_err, seq_index, rom_addr});
        end
        @(negedge clk) rstn = 1'b1;
        repeat (100) @(negedge clk);
        n_chk++;
        if (start_cyc.size() != 2 || seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: starts=%0d busy=%b, required 2 and 0", start_cyc.size(), seq_busy);
        end
    endtask

    task automatic test_go_ignored();
        tbl = '{24'h300882, 24'h310303, 24'h3012AB, 24'hFFFE00};
        clear_log();
        pulse_go();
        wait_starts(1, 100);
        repeat (5) @(negedge clk);
        pulse_go();
        repeat (10) @(negedge clk);
        pulse_go();
        wait_seq_end("goign", 800);
        n_chk++;
        if (start_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL goign_start_count: got %0d, required 3", start_cyc.size());
        end else begin
            n_chk++;
            if (start_cyc[1] - start_cyc[0] != HOLD + 5 || start_cyc[2] - start_cyc[1] != HOLD + 5) begin
                n_fail++;
                $display("FAIL goign_gaps: got %0d and %0d, required %0d",
                         start_cyc[1] - start_cyc[0], start_cyc[2] - start_cyc[1], HOLD + 5);
            end
            n_chk++;
            if (start_dat[1] !== 32'h78310303 || start_dat[2] !== 32'h783012AB) begin
                n_fail++;
                $display("FAIL goign_order: got %h %h, required 78310303 783012AB", start_dat[1], start_dat[2]);
            end
        end
        n_chk++;
        if (seq_done !== 1'b1 || seq_index !== 2'd3) begin
            n_fail++;
            $display("FAIL goign_end_state: done=%b index=%0d, required 1 and 3", seq_done, seq_index);
        end
    endtask

    initial begin
        tbl = '{24'h0, 24'h0, 24'h0, 24'h0};
        test_reset();
        test_rom();
        test_two_writes();
        test_delay();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_go_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
